axi_buffer_rab_flex: RTL

//  Parametrised elastic buffer for RAB AXI channels (AW/W/AR/R/B). Valid/ready on both sides.

---
 rtl/axi_rab_buffer_pkg.sv | 17 +
 rtl/axi_buffer_rab_wrap_ctr.sv | 28 ++
 rtl/axi_buffer_rab_flex.sv | 117 +++++++++++
 3 files changed

// File: rtl/axi_rab_buffer_pkg.sv
// Shared definitions for the RAB AXI elastic buffers: pointer wrap helper and
// the legal parameter bounds checked at elaboration.
package axi_rab_buffer_pkg;

  // Smallest depth that still lets the buffer decouple both sides.
  localparam int unsigned MIN_DEPTH     = 2;
  // Lowest meaningful almost-full threshold.
  localparam int unsigned MIN_AF_THRESH = 1;

  // Next pointer value with an explicit wrap at depth-1, so non-power-of-2
  // depths index only valid entries.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/axi_buffer_rab_wrap_ctr.sv
// Pointer counter that wraps at DEPTH-1; used for both read and write pointers.
module axi_buffer_rab_wrap_ctr
  import axi_rab_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  output logic [PTR_W-1:0] count
);

  // Advance on enable, return to zero on reset or clear (reset wins).
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= PTR_W'(ptr_inc(32'(count), DEPTH));
    end
  end

endmodule

// File: rtl/axi_buffer_rab_flex.sv
// Elastic valid/ready buffer for the RAB AXI channels. Supports any depth >= 2,
// optional fall-through when empty, fill level / almost-full outputs and a
// synchronous flush that drops all stored beats.
module axi_buffer_rab_flex
  import axi_rab_buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 4,
  parameter int FALL_THROUGH = 0,
  parameter int AF_THRESH    = 3,
  localparam int PTR_W       = $clog2(BUFFER_DEPTH),
  localparam int CNT_W       = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [CNT_W-1:0]      elements,
  output logic                  almost_full
);

  if (BUFFER_DEPTH < int'(MIN_DEPTH)) begin : g_bad_depth
    $error("axi_buffer_rab_flex: BUFFER_DEPTH must be >= 2");
  end
  if (AF_THRESH < int'(MIN_AF_THRESH) || AF_THRESH > BUFFER_DEPTH) begin : g_bad_af
    $error("axi_buffer_rab_flex: AF_THRESH must be in 1..BUFFER_DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [PTR_W-1:0]      ptr_in;
  logic [PTR_W-1:0]      ptr_out;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  pass;
  logic                  push;
  logic                  pop;

  assign full  = (count == CNT_W'(BUFFER_DEPTH));
  assign empty = (count == '0);

  // A fall-through pass consumes the beat directly; it is never stored.
  assign pass = (FALL_THROUGH != 0) && empty && valid_in && ready_in && !flush;
  assign push = valid_in && ready_out && !pass;
  assign pop  = valid_out && ready_in && !empty;

  // Output selection: stored head, or the live input when empty in fall-through mode.
  always_comb begin
    // NOTE: every output gets a value on every path, so no latch is inferred.
    ready_out = !full && !flush;
    valid_out = !empty && !flush;
    data_out  = mem[ptr_out];
    if (FALL_THROUGH != 0 && empty) begin
      valid_out = valid_in && !flush;
      data_out  = data_in;
    end
  end

  assign elements    = count;
  assign almost_full = (count >= CNT_W'(AF_THRESH));

  axi_buffer_rab_wrap_ctr #(
    .DEPTH (BUFFER_DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr_in (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (flush),
    .en    (push),
    .count (ptr_in)
  );

  axi_buffer_rab_wrap_ctr #(
    .DEPTH (BUFFER_DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr_out (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (flush),
    .en    (pop),
    .count (ptr_out)
  );

  // Fill level: up on push only, down on pop only; flush empties the buffer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; reset zeroes entries so data_out reads 0 after reset.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is reset deliberately (data_out must be 0 after
    // reset); flush leaves contents untouched since the pointers hide them.
    if (!rstn) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[ptr_in] <= data_in;
    end
  end

endmodule
